prf_alloc_ctrl: RTL and testbench

- Rename-stage allocation controller for the physical register file.
- Tracks how many PRF entries are free, and grants each cycle the longest in-order prefix of the N decoded instructions that fits both the free-register count and the downstream dispatch slots.
- After a nuke it runs a recovery window: grants are held off while the rename table is restored from the retirement table, and the free count is reloaded.
- Sits between decode and the rename table / free-list logic; grants gate the rename table's allocation.

---
 rtl/sys_defs.sv | 19 +
 rtl/popcount.sv | 20 ++
 rtl/prf_alloc_ctrl.sv | 159 +++++++++++++++
 tb/tb_prf_alloc_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sys_defs : shared types and widths for the PRF allocation controller
// Rev 1.0
// ---------------------------------------------------------------------------
`ifndef N
`define N 3
`endif
`ifndef PRF_NUM_ENTRIES
`define PRF_NUM_ENTRIES 64
`endif

package sys_defs;
  typedef enum logic {ALLOC_RUN, ALLOC_RECOVER} ALLOC_STATE;

  localparam int ALLOC_CW = $clog2(`PRF_NUM_ENTRIES + 1);
  localparam int ALLOC_SW = $clog2(`N + 1);
endpackage
`default_nettype wire

// File: rtl/popcount.sv
`default_nettype none
// ---------------------------------------------------------------------------
// popcount : number of set bits in a vector
// Rev 1.0
// ---------------------------------------------------------------------------
module popcount #(
  parameter int WIDTH = 64,
  parameter int OUT_W = 7
) (
  input  logic [WIDTH-1:0] in_vec,
  output logic [OUT_W-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + OUT_W'(in_vec[i]);
    end
  end
endmodule
`default_nettype wire

// File: rtl/prf_alloc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prf_alloc_ctrl : rename-stage PRF allocation / nuke recovery controller
// Optional stall/recovery statistics with PRF_ALLOC_STATS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`ifndef N
`define N 3
`endif
`ifndef PRF_NUM_ENTRIES
`define PRF_NUM_ENTRIES 64
`endif

module prf_alloc_ctrl
  import sys_defs::*;
#(
  parameter int N              = `N,
  parameter int PRF_ENTRIES    = `PRF_NUM_ENTRIES,
  parameter int RECOVER_CYCLES = 2,
  localparam int CW            = $clog2(PRF_ENTRIES + 1),
  localparam int SW            = $clog2(N + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   nuke,
  input  logic [PRF_ENTRIES-1:0] rrat_free_list,
  input  logic [PRF_ENTRIES-1:0] free_vector_from_rrat,
  input  logic [N-1:0]           req_valid,
  input  logic [N-1:0]           req_dest_valid,
  input  logic [SW-1:0]          dispatch_slots,
  output logic [N-1:0]           grant,
  output logic [SW-1:0]          grant_count,
  output logic [SW-1:0]          alloc_count,
  output logic                   rename_stall,
  output logic [CW-1:0]          free_count,
  output logic                   recovering
`ifdef PRF_ALLOC_STATS_EN
  ,
  output logic [31:0]            stall_prf_cycles,
  output logic [31:0]            stall_slot_cycles,
  output logic [31:0]            recover_cycles_total
`endif
);
  localparam int RCW = $clog2(RECOVER_CYCLES + 1);

  ALLOC_STATE     state;
  logic [RCW-1:0] rec_cnt;
  logic [CW-1:0]  freed_cnt;
  logic [CW-1:0]  rrat_cnt;
  logic [CW:0]    need;
  logic           chain;
  logic           prf_limited;
  logic           slot_limited;
  logic [CW:0]    next_free_raw;
  logic [CW-1:0]  next_free;

  popcount #(.WIDTH(PRF_ENTRIES), .OUT_W(CW)) u_pop_freed (
    .in_vec (free_vector_from_rrat),
    .count  (freed_cnt)
  );

  popcount #(.WIDTH(PRF_ENTRIES), .OUT_W(CW)) u_pop_rrat (
    .in_vec (rrat_free_list),
    .count  (rrat_cnt)
  );

  // In-order prefix grant; the first denied slot records why it was denied.
  always_comb begin
    grant        = '0;
    prf_limited  = 1'b0;
    slot_limited = 1'b0;
    need         = '0;
    chain        = (state == ALLOC_RUN) && !nuke && !reset;
    for (int i = 0; i < N; i++) begin
      need = need + (CW+1)'(req_dest_valid[i]);
      if (chain && req_valid[i]) begin
        if (need > {1'b0, free_count}) begin
          prf_limited = 1'b1;
          chain       = 1'b0;
        end else if (i >= int'(dispatch_slots)) begin
          slot_limited = 1'b1;
          chain        = 1'b0;
        end else begin
          grant[i] = 1'b1;
        end
      end else begin
        chain = 1'b0;
      end
    end
  end

  always_comb begin
    grant_count = '0;
    alloc_count = '0;
    for (int i = 0; i < N; i++) begin
      grant_count = grant_count + SW'(grant[i]);
      alloc_count = alloc_count + SW'(grant[i] & req_dest_valid[i]);
    end
    rename_stall = !reset && |(req_valid & ~grant);
    recovering   = (state == ALLOC_RECOVER);
  end

  always_comb begin
    if (state == ALLOC_RUN) begin
      next_free_raw = {1'b0, free_count} - (CW+1)'(alloc_count) + (CW+1)'(freed_cnt);
    end else begin
      next_free_raw = {1'b0, free_count} + (CW+1)'(freed_cnt);
    end
    next_free = (next_free_raw > (CW+1)'(PRF_ENTRIES)) ? CW'(PRF_ENTRIES)
                                                        : next_free_raw[CW-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ALLOC_RUN;
      free_count <= CW'(PRF_ENTRIES);
      rec_cnt    <= '0;
    end else if (nuke) begin
      state      <= ALLOC_RECOVER;
      rec_cnt    <= RCW'(RECOVER_CYCLES - 1);
      free_count <= rrat_cnt;
    end else begin
      free_count <= next_free;
      if (state == ALLOC_RECOVER) begin
        if (rec_cnt == '0) state <= ALLOC_RUN;
        else               rec_cnt <= rec_cnt - 1'b1;
      end
    end
  end

`ifdef PRF_ALLOC_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_prf_cycles     <= '0;
      stall_slot_cycles    <= '0;
      recover_cycles_total <= '0;
    end else begin
      if (prf_limited)                    stall_prf_cycles     <= stall_prf_cycles + 32'd1;
      else if (slot_limited)              stall_slot_cycles    <= stall_slot_cycles + 32'd1;
      if (state == ALLOC_RECOVER)         recover_cycles_total <= recover_cycles_total + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  logic [N-1:0] req_valid_inc;
  assign req_valid_inc = req_valid + N'(1);

  a_contiguous_req : assert property (@(posedge clock) disable iff (reset)
    (req_valid & req_valid_inc) == '0);
  a_free_no_overflow : assert property (@(posedge clock) disable iff (reset)
    (!nuke && state == ALLOC_RUN) |-> (next_free_raw <= (CW+1)'(PRF_ENTRIES)));
`endif

`ifndef PRF_ALLOC_STATS_EN
  logic unused_stats;
  assign unused_stats = prf_limited ^ slot_limited;
`endif
endmodule
`default_nettype wire

// File: tb/tb_prf_alloc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_prf_alloc_ctrl : directed vectors with a queue-based scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_prf_alloc_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        nuke;
  logic [63:0] rrat_free_list;
  logic [63:0] free_vector_from_rrat;
  logic [2:0]  req_valid;
  logic [2:0]  req_dest_valid;
  logic [1:0]  dispatch_slots;
  logic [2:0]  grant;
  logic [1:0]  grant_count;
  logic [1:0]  alloc_count;
  logic        rename_stall;
  logic [6:0]  free_count;
  logic        recovering;
`ifdef PRF_ALLOC_STATS_EN
  logic [31:0] stall_prf_cycles;
  logic [31:0] stall_slot_cycles;
  logic [31:0] recover_cycles_total;
`endif

  prf_alloc_ctrl #(.N(3), .PRF_ENTRIES(64), .RECOVER_CYCLES(2)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .nuke                  (nuke),
    .rrat_free_list        (rrat_free_list),
    .free_vector_from_rrat (free_vector_from_rrat),
    .req_valid             (req_valid),
    .req_dest_valid        (req_dest_valid),
    .dispatch_slots        (dispatch_slots),
    .grant                 (grant),
    .grant_count           (grant_count),
    .alloc_count           (alloc_count),
    .rename_stall          (rename_stall),
    .free_count            (free_count),
    .recovering            (recovering)
`ifdef PRF_ALLOC_STATS_EN
    ,
    .stall_prf_cycles      (stall_prf_cycles),
    .stall_slot_cycles     (stall_slot_cycles),
    .recover_cycles_total  (recover_cycles_total)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int id;
    int g;
    int gc;
    int ac;
    int st;
    int fr;
    int rec;
    int cs;
    int sp;
    int ss;
    int sr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   row   = 0;

  task automatic chk(input string nm, input int id, input int act, input int e);
    total++;
    if (act != e) begin
      bad++;
      $display("FAIL %s row %0d: got %0d required %0d", nm, id, act, e);
    end
  endtask

  function automatic logic [63:0] ones(input int k);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) if (i < k) v[i] = 1'b1;
    return v;
  endfunction

  // Monitor: one expected entry per cycle, compared away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("grant",        e.id, int'(grant),        e.g);
        chk("grant_count",  e.id, int'(grant_count),  e.gc);
        chk("alloc_count",  e.id, int'(alloc_count),  e.ac);
        chk("rename_stall", e.id, int'(rename_stall), e.st);
        chk("free_count",   e.id, int'(free_count),   e.fr);
        chk("recovering",   e.id, int'(recovering),   e.rec);
`ifdef PRF_ALLOC_STATS_EN
        if (e.cs != 0) begin
          chk("stall_prf_cycles",     e.id, int'(stall_prf_cycles),     e.sp);
          chk("stall_slot_cycles",    e.id, int'(stall_slot_cycles),    e.ss);
          chk("recover_cycles_total", e.id, int'(recover_cycles_total), e.sr);
        end
`endif
      end
    end
  end

  task automatic vec(input logic rs, input logic nk, input logic [2:0] rv,
                     input logic [2:0] dv, input logic [1:0] sl, input int fvn,
                     input int rrn, input int eg, input int egc, input int eac,
                     input int est, input int efr, input int erec,
                     input int cs = 0, input int sp = 0, input int ss = 0,
                     input int sr = 0);
    exp_t e;
    @(posedge clock);
    #1;
    reset                 = rs;
    nuke                  = nk;
    req_valid             = rv;
    req_dest_valid        = dv;
    dispatch_slots        = sl;
    free_vector_from_rrat = ones(fvn);
    rrat_free_list        = ones(rrn);
    e.id = row; e.g = eg; e.gc = egc; e.ac = eac; e.st = est; e.fr = efr;
    e.rec = erec; e.cs = cs; e.sp = sp; e.ss = ss; e.sr = sr;
    q.push_back(e);
    row++;
  endtask

  initial begin
    reset = 1'b1; nuke = 1'b0; req_valid = '0; req_dest_valid = '0;
    dispatch_slots = '0; free_vector_from_rrat = '0; rrat_free_list = '0;
    //   rst nk  rv      dv      sl fv rr   g  gc ac st fr  rec
    vec(1, 0, 3'b111, 3'b111, 3, 0, 0,   0, 0, 0, 0, 64, 0);
    vec(0, 0, 3'b000, 3'b000, 3, 0, 0,   0, 0, 0, 0, 64, 0);
    vec(0, 0, 3'b111, 3'b111, 3, 0, 0,   7, 3, 3, 0, 64, 0);
    vec(0, 1, 3'b111, 3'b111, 3, 0, 40,  0, 0, 0, 1, 61, 0);
    vec(0, 0, 3'b111, 3'b111, 3, 2, 0,   0, 0, 0, 1, 40, 1);
    vec(0, 0, 3'b000, 3'b000, 3, 0, 0,   0, 0, 0, 0, 42, 1);
    vec(0, 0, 3'b111, 3'b111, 3, 0, 0,   7, 3, 3, 0, 42, 0);
    vec(0, 0, 3'b111, 3'b111, 1, 0, 0,   1, 1, 1, 1, 39, 0);
    vec(0, 0, 3'b111, 3'b111, 0, 0, 0,   0, 0, 0, 1, 38, 0);
    vec(0, 0, 3'b001, 3'b000, 3, 0, 0,   1, 1, 0, 0, 38, 0);
    vec(0, 1, 3'b000, 3'b000, 3, 0, 1,   0, 0, 0, 0, 38, 0);
    vec(0, 1, 3'b000, 3'b000, 3, 0, 1,   0, 0, 0, 0, 1,  1);
    vec(0, 0, 3'b000, 3'b000, 3, 0, 0,   0, 0, 0, 0, 1,  1);
    vec(0, 0, 3'b000, 3'b000, 3, 0, 0,   0, 0, 0, 0, 1,  1);
    vec(0, 0, 3'b111, 3'b101, 3, 2, 0,   3, 2, 1, 1, 1,  0);
    vec(0, 0, 3'b111, 3'b111, 3, 0, 0,   3, 2, 2, 1, 2,  0);
    vec(0, 0, 3'b111, 3'b110, 3, 0, 0,   1, 1, 0, 1, 0,  0);
    vec(0, 0, 3'b000, 3'b000, 3, 5, 0,   0, 0, 0, 0, 0,  0);
    vec(0, 0, 3'b000, 3'b000, 3, 0, 0,   0, 0, 0, 0, 5,  0);
    vec(0, 1, 3'b000, 3'b000, 3, 0, 40,  0, 0, 0, 0, 5,  0);
    vec(0, 0, 3'b111, 3'b111, 3, 0, 0,   0, 0, 0, 1, 40, 1, 1, 3, 2, 5);
    vec(1, 0, 3'b111, 3'b111, 3, 0, 0,   0, 0, 0, 0, 64, 0, 1, 0, 0, 0);
    vec(0, 0, 3'b111, 3'b111, 3, 0, 0,   7, 3, 3, 0, 64, 0);
    vec(0, 0, 3'b000, 3'b000, 3, 0, 0,   0, 0, 0, 0, 61, 0);
    repeat (3) @(posedge clock);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
